fifo_sync_flex: RTL and testbench

Single-clock, parameterised synchronous FIFO: the same-clock counterpart to the dual-clock FIFO, used wherever producer and consumer share one clock. Beyond the basic FIFO it supports non-power-of-2 depth, a selectable read mode (first-word-fall-through or registered output), programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

---
 rtl/fifo_sync_flex.sv | 130 +++++++++++++
 tb/tb_fifo_sync_flex.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with arbitrary depth and a selectable FWFT or registered read port.
// It also provides programmable almost-flags, an occupancy count and sticky error flags.
module fifo_sync_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 1,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Wen,
  input  logic [DATA_WIDTH-1:0] WrData,
  input  logic                  Ren,
  input  logic                  ClrErr,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdValid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int PTR_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "fifo_sync_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $fatal(1, "fifo_sync_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
    $fatal(1, "fifo_sync_flex: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wen_q;
  logic                  ren_q;

  // Flags decode from the registered count only, never from Wen/Ren.
  assign Full        = (count_q == CNT_WIDTH'(DEPTH));
  assign Empty       = (count_q == '0);
  assign AlmostFull  = (count_q >= CNT_WIDTH'(AF_THRESH));
  assign AlmostEmpty = (count_q <= CNT_WIDTH'(AE_THRESH));
  assign Count       = count_q;
  assign Overflow    = overflow_q;
  assign Underflow   = underflow_q;

  assign wen_q = Wen & ~Full;
  assign ren_q = Ren & ~Empty;

  always_ff @(posedge Clk) begin
    if (wen_q) begin
      mem[wr_ptr] <= WrData;
    end
  end

  // Explicit wrap keeps non-power-of-2 depths correct.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wen_q) begin
        wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (ren_q) begin
        rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
      case ({wen_q, ren_q})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set has priority over ClrErr.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (Wen & Full) begin
        overflow_q <= 1'b1;
      end else if (ClrErr) begin
        overflow_q <= 1'b0;
      end
      if (Ren & Empty) begin
        underflow_q <= 1'b1;
      end else if (ClrErr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign RdData  = mem[rd_ptr];
    assign RdValid = ~Empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= ren_q;
        if (ren_q) begin
          rd_data_q <= mem[rd_ptr];
        end
      end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: an FWFT and a registered-read instance (DEPTH=5) share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_sync_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF_T  = 4;
  localparam int AE_T  = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk;
  logic          Rst;
  logic          Wen;
  logic [DW-1:0] WrData;
  logic          Ren;
  logic          ClrErr;

  logic [DW-1:0] f_rd_data, r_rd_data;
  logic          f_rd_valid, r_rd_valid;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [CW-1:0] f_count, r_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf, m_rvalid;
  logic [DW-1:0] m_rdata;

  fifo_sync_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                   .AF_THRESH(AF_T), .AE_THRESH(AE_T)) u_fwft (
    .Clk(Clk), .Rst(Rst), .Wen(Wen), .WrData(WrData), .Ren(Ren), .ClrErr(ClrErr),
    .RdData(f_rd_data), .RdValid(f_rd_valid), .Full(f_full), .Empty(f_empty),
    .AlmostFull(f_af), .AlmostEmpty(f_ae), .Count(f_count),
    .Overflow(f_ovf), .Underflow(f_udf)
  );

  fifo_sync_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                   .AF_THRESH(AF_T), .AE_THRESH(AE_T)) u_reg (
    .Clk(Clk), .Rst(Rst), .Wen(Wen), .WrData(WrData), .Ren(Ren), .ClrErr(ClrErr),
    .RdData(r_rd_data), .RdValid(r_rd_valid), .Full(r_full), .Empty(r_empty),
    .AlmostFull(r_af), .AlmostEmpty(r_ae), .Count(r_count),
    .Overflow(r_ovf), .Underflow(r_udf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  // Drives one cycle of stimulus and advances the reference model; no checks here.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    int n;
    Wen = w; WrData = d; Ren = r; ClrErr = c;
    @(posedge Clk);
    n = q.size();
    if (w && n == DEPTH) m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (r && n == 0)     m_udf = 1'b1;
    else if (c)          m_udf = 1'b0;
    m_rvalid = 1'b0;
    if (r && n > 0) begin
      m_rdata  = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (w && n < DEPTH) q.push_back(d);
    #1;
    Wen = 1'b0; Ren = 1'b0; ClrErr = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Wen = 1'b0; Ren = 1'b0; ClrErr = 1'b0; WrData = '0;
    model_reset();
    #2;
    checks++;
    if (f_count !== 0 || f_empty !== 1'b1 || f_full !== 1'b0 || f_ae !== 1'b1 || f_af !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b ae=%b af=%b, need 0 1 0 1 0",
               f_count, f_empty, f_full, f_ae, f_af);
    end
    checks++;
    if (f_ovf !== 1'b0 || f_udf !== 1'b0 || f_rd_valid !== 1'b0 || r_rd_valid !== 1'b0 || r_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ovf=%b udf=%b fvalid=%b rvalid=%b rdata=%h, need 0 0 0 0 00",
               f_ovf, f_udf, f_rd_valid, r_rd_valid, r_rd_data);
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
      checks++;
      if (f_count !== CW'(i + 1) || r_count !== CW'(i + 1)) begin
        errors++;
        $display("FAIL fill_count: fwft=%0d reg=%0d, need %0d", f_count, r_count, i + 1);
      end
    end
    checks++;
    if (f_full !== 1'b1 || f_af !== 1'b1 || f_rd_data !== 8'h11) begin
      errors++;
      $display("FAIL fill_full: full=%b af=%b head=%h, need 1 1 11", f_full, f_af, f_rd_data);
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    checks++;
    if (f_ovf !== 1'b1 || f_count !== CW'(DEPTH) || f_rd_data !== 8'h11 || r_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d head=%h, need 1 5 11", f_ovf, f_count, f_rd_data);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (f_rd_data !== DW'(8'h11 + i) || f_rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_fwft[%0d]: data=%h valid=%b, need %h 1", i, f_rd_data, f_rd_valid, 8'h11 + i);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (r_rd_data !== DW'(8'h11 + i) || r_rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_reg[%0d]: data=%h valid=%b, need %h 1", i, r_rd_data, r_rd_valid, 8'h11 + i);
      end
    end
    checks++;
    if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_count !== 0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b valid=%b count=%0d, need 1 0 0", f_empty, f_rd_valid, f_count);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (f_udf !== 1'b1 || f_ovf !== 1'b1 || r_rd_valid !== 1'b0 || r_rd_data !== 8'h15) begin
      errors++;
      $display("FAIL underflow: udf=%b ovf=%b rvalid=%b rdata=%h, need 1 1 0 15",
               f_udf, f_ovf, r_rd_valid, r_rd_data);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (f_udf !== 1'b0 || f_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: udf=%b ovf=%b, need 0 0", f_udf, f_ovf);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = DW'($urandom);
      step(1'b1, d, 1'b1, 1'b0);
      checks++;
      if (f_count !== CW'(2) || r_rd_data !== m_rdata || r_rd_valid !== 1'b1 || f_rd_data !== q[0]) begin
        errors++;
        $display("FAIL wrap[%0d]: count=%0d rdata=%h head=%h, need 2 %h %h",
                 i, f_count, r_rd_data, f_rd_data, m_rdata, q[0]);
      end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (r_rd_data !== m_rdata || f_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_tail: rdata=%h empty=%b, need %h 1", r_rd_data, f_empty, m_rdata);
    end
  endtask

  task automatic test_reg_latency();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (r_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reg_write_novalid: valid=%b, need 0", r_rd_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (r_rd_data !== 8'hA5 || r_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reg_latency: data=%h valid=%b, need a5 1", r_rd_data, r_rd_valid);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (r_rd_data !== 8'hA5 || r_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold: data=%h valid=%b, need a5 0", r_rd_data, r_rd_valid);
    end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
      checks++;
      if (f_ae !== (k <= AE_T) || f_af !== (k >= AF_T)) begin
        errors++;
        $display("FAIL thresh[count=%0d]: ae=%b af=%b, need %b %b", k, f_ae, f_af, k <= AE_T, k >= AF_T);
      end
    end
  endtask

  task automatic test_clrerr_set_wins();
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    checks++;
    if (f_ovf !== 1'b1 || f_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL set_wins: ovf=%b count=%0d, need 1 5", f_ovf, f_count);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (f_count !== CW'(3) || f_ovf !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: count=%0d ovf=%b, need 3 1", f_count, f_ovf);
    end
    #3 Rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (f_count !== 0 || f_empty !== 1'b1 || f_ovf !== 1'b0 || f_udf !== 1'b0 ||
        r_count !== 0 || r_rd_valid !== 1'b0 || r_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b ovf=%b udf=%b rvalid=%b rdata=%h, need 0 1 0 0 0 00",
               f_count, f_empty, f_ovf, f_udf, r_rd_valid, r_rd_data);
    end
    #2 Rst = 1'b0;
  endtask

  task automatic test_random();
    int n;
    logic w, r;
    for (int i = 0; i < 400; i++) begin
      w = (i < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step(w, DW'($urandom), r, $urandom_range(9) == 0);
      n = q.size();
      checks++;
      if (f_count !== CW'(n) || r_count !== CW'(n) || f_full !== (n == DEPTH) || f_empty !== (n == 0) ||
          f_af !== (n >= AF_T) || f_ae !== (n <= AE_T)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: count=%0d full=%b empty=%b af=%b ae=%b, need count %0d",
                 i, f_count, f_full, f_empty, f_af, f_ae, n);
      end
      checks++;
      if (f_ovf !== m_ovf || f_udf !== m_udf || r_ovf !== m_ovf || r_udf !== m_udf) begin
        errors++;
        $display("FAIL rand_err[%0d]: ovf=%b udf=%b, need %b %b", i, f_ovf, f_udf, m_ovf, m_udf);
      end
      checks++;
      if (r_rd_valid !== m_rvalid || r_rd_data !== m_rdata || f_rd_valid !== (n > 0)) begin
        errors++;
        $display("FAIL rand_read[%0d]: rvalid=%b rdata=%h fvalid=%b, need %b %h %b",
                 i, r_rd_valid, r_rd_data, f_rd_valid, m_rvalid, m_rdata, n > 0);
      end
      if (n > 0) begin
        checks++;
        if (f_rd_data !== q[0]) begin
          errors++;
          $display("FAIL rand_head[%0d]: head=%h, need %h", i, f_rd_data, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_reg_latency();
    test_thresholds();
    test_clrerr_set_wins();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
